// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command FIFO and registered result stage around a combinational ALU
module alu_cmd_issue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_in1,
  input  logic [WIDTH-1:0]           cmd_in2,
  input  logic [OPW-1:0]             cmd_op,
  output logic [WIDTH-1:0]           alu_in1,
  output logic [WIDTH-1:0]           alu_in2,
  output logic [OPW-1:0]             alu_op,
  input  logic [WIDTH:0]             alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH:0]             res_data,
  output logic [OPW-1:0]             res_op,
  output logic                       res_illegal,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
  localparam logic [OPW-1:0] MAX_OP = OPW'(4);

  logic [WIDTH-1:0] mem_in1 [DEPTH];
  logic [WIDTH-1:0] mem_in2 [DEPTH];
  logic [OPW-1:0]   mem_op  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          out_free;
  logic          push;
  logic          pop;

  // No push-through at full: a same-cycle pop does not free a slot for the push.
  assign not_empty  = (count != '0);
  assign cmd_ready  = (count != FULL) & ~rst;
  assign push       = cmd_valid & cmd_ready;
  assign out_free   = ~res_valid | res_ready;
  assign pop        = not_empty & out_free;
  assign fifo_count = count;

  assign alu_in1 = not_empty ? mem_in1[rd_ptr] : '0;
  assign alu_in2 = not_empty ? mem_in2[rd_ptr] : '0;
  assign alu_op  = not_empty ? mem_op[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_in1[wr_ptr] <= cmd_in1;
      mem_in2[wr_ptr] <= cmd_in2;
      mem_op[wr_ptr]  <= cmd_op;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_illegal <= 1'b0;
    end else if (pop) begin
      res_valid   <= 1'b1;
      res_data    <= alu_out;
      res_op      <= mem_op[rd_ptr];
      res_illegal <= (mem_op[rd_ptr] > MAX_OP);
    end else if (res_valid && res_ready) begin
      res_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - scoreboard bench for alu_cmd_issue with a behavioural ALU
module tb_alu_cmd_issue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int OPW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_in1, cmd_in2;
  logic [OPW-1:0]    cmd_op;
  logic [WIDTH-1:0]  alu_in1, alu_in2;
  logic [OPW-1:0]    alu_op;
  logic [WIDTH:0]    alu_out;
  logic              res_valid;
  logic              res_ready;
  logic [WIDTH:0]    res_data;
  logic [OPW-1:0]    res_op;
  logic              res_illegal;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed {
    logic [WIDTH:0] data;
    logic [OPW-1:0] op;
    logic           illegal;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_accepts = 0;
  int   n_results = 0;
  int   max_count = 0;
  bit   track = 1'b0;

  alu_cmd_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_op(cmd_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_illegal(res_illegal),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_alu(input logic [WIDTH-1:0] a, b, input logic [OPW-1:0] op);
    case (op)
      3'd0:    ref_alu = {1'b0, a} + {1'b0, b};
      3'd1:    ref_alu = {1'b0, a} - {1'b0, b};
      3'd2:    ref_alu = {1'b0, a & b};
      3'd3:    ref_alu = {1'b0, a | b};
      3'd4:    ref_alu = {1'b0, a ^ b};
      default: ref_alu = '0;
    endcase
  endfunction

  always_comb alu_out = ref_alu(alu_in1, alu_in2, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change at posedge+1; both handshakes are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      sb.push_back('{data: ref_alu(cmd_in1, cmd_in2, cmd_op), op: cmd_op,
                     illegal: (cmd_op > 3'd4)});
      n_accepts++;
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_op", 32'(res_op), 32'(e.op));
        check("res_illegal", 32'(res_illegal), 32'(e.illegal));
      end
      n_results++;
    end
    if (track && int'(fifo_count) > max_count) max_count = int'(fifo_count);
  end

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, b, input logic [OPW-1:0] op);
    bit done;
    done = 1'b0;
    cmd_in1 = a; cmd_in2 = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_res, base_acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_in1 = '0; cmd_in2 = '0; cmd_op = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_res_data", 32'(res_data), 32'd0);
    check("reset_res_op", 32'({res_illegal, res_op}), 32'd0);
    check("reset_alu_in", 32'({alu_in1, alu_op}), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Add with carry and first-result latency.
    send(16'hFFFF, 16'h0001, 3'd0);
    @(negedge clk);
    check("lat_valid_early", 32'(res_valid), 32'd0);
    check("lat_fifo_count", 32'(fifo_count), 32'd1);
    check("lat_alu_in1", 32'(alu_in1), 32'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid", 32'(res_valid), 32'd1);
    check("add_carry_data", 32'(res_data), 32'h10000);
    check("add_carry_illegal", 32'(res_illegal), 32'd0);
    @(posedge clk); #1;

    send(16'h0003, 16'h0005, 3'd1);
    send(16'hF0F0, 16'h0FF0, 3'd2);
    send(16'hF0F0, 16'h0FF0, 3'd3);
    send(16'hF0F0, 16'h0FF0, 3'd4);
    repeat (3) cycle();
    check("logic_ops_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: FIFO fills plus one held result.
    res_ready = 1'b0;
    base_acc = n_accepts;
    for (int j = 0; j < 8; j++) begin
      cmd_in1 = 16'h0100 + 16'(j); cmd_in2 = 16'(j + 1); cmd_op = 3'(j % 5); cmd_valid = 1'b1;
      @(negedge clk);
      if (j >= 2) check("stall_data", 32'(res_data), 32'h00101);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepts", 32'(n_accepts - base_acc), 32'd5);
    @(negedge clk);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_res_data", 32'(res_data), 32'h00101);
    @(posedge clk); #1;
    base_res = n_results;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(res_valid), 32'd1);
      if (i == 0) check("drain_cmd_ready_before", 32'(cmd_ready), 32'd0);
      if (i == 1) check("drain_cmd_ready_after", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_done_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("drain_count", 32'(n_results - base_res), 32'd5);

    // Illegal opcode passes the ALU zero through.
    send(16'h1234, 16'h5678, 3'd6);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_valid", 32'(res_valid), 32'd1);
    check("illegal_data", 32'(res_data), 32'd0);
    check("illegal_op", 32'(res_op), 32'd6);
    check("illegal_flag", 32'(res_illegal), 32'd1);
    @(posedge clk); #1;

    // Streaming with wrap-around.
    base_res = n_results; base_acc = n_accepts;
    max_count = 0; track = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_in1 = 16'($urandom); cmd_in2 = 16'($urandom); cmd_op = 3'($urandom_range(0, 7));
      cmd_valid = 1'b1;
      cycle();
    end
    cmd_valid = 1'b0;
    repeat (3) cycle();
    track = 1'b0;
    check("stream_accepts", 32'(n_accepts - base_acc), 32'd10);
    check("stream_results", 32'(n_results - base_res), 32'd10);
    check("stream_max_count_le1", 32'(max_count <= 1), 32'd1);

    // Reset mid-operation.
    res_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cmd_in1 = 16'h0A00 + 16'(j); cmd_in2 = 16'h0011; cmd_op = 3'd0; cmd_valid = 1'b1;
      cycle();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(res_valid), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_alu", 32'({alu_in1, alu_op}), 32'd0);
    check("post_rst_alu_in2", 32'(alu_in2), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    base_res = n_results;
    send(16'h7FFF, 16'h7FFF, 3'd0);
    repeat (3) cycle();
    check("post_rst_result", 32'(n_results - base_res), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
